spi_servo_cmd_parser: RTL and testbench

- Sits directly downstream of the SPI slave byte engine in the spider-robot FPGA.
- Consumes the received byte and its one-cycle done strobe, and frames 5-byte servo commands.
- Checks each frame, clamps the position and issues a one-cycle servo write to the PWM bank.
- Returns a status byte (and send enable) to the SPI engine for the master to read back on later transfers.

---
 rtl/spi_servo_cmd_parser.sv | 173 +++++++++++++++++
 tb/tb_spi_servo_cmd_parser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_servo_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : spi_servo_cmd_parser
// Description : Frames 5-byte servo commands (header, id, pos_hi, pos_lo,
//               xor checksum) received from the SPI slave byte engine,
//               validates them, clamps the position and issues a one-cycle
//               servo write. Reports a status byte back to the SPI engine.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_servo_cmd_parser #(
  parameter int          NUM_SERVO = 18,
  parameter logic [15:0] POS_MIN   = 16'd500,
  parameter logic [15:0] POS_MAX   = 16'd2500,
  parameter logic [23:0] TIMEOUT   = 24'd500000,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ncs_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_call_o,
  output logic        servo_wr_o,
  output logic [4:0]  servo_id_o,
  output logic [15:0] servo_pos_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_ID  = 3'd1,
    S_PH  = 3'd2,
    S_PL  = 3'd3,
    S_CK  = 3'd4
  } state_t;

  localparam logic [7:0] C_ID_LIMIT = 8'(NUM_SERVO);

  state_t      state_q;
  logic [2:0]  cs_sync_q;
  logic [7:0]  id_q;
  logic [7:0]  pos_hi_q;
  logic [7:0]  pos_lo_q;
  logic [7:0]  ck_q;
  logic [23:0] to_cnt_q;
  logic [3:0]  pkt_cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_call_q;
  logic        servo_wr_q;
  logic [4:0]  servo_id_q;
  logic [15:0] servo_pos_q;
  logic [7:0]  err_cnt_q;

  logic        cs_t;
  logic [15:0] pos_raw;
  logic [15:0] pos_clamped;
  logic        id_ok;
  logic        ck_ok;
  logic        to_hit;
  logic [7:0]  err_cnt_inc;
  logic [3:0]  pkt_cnt_inc;

  assign cs_t        = cs_sync_q[2];
  assign pos_raw     = {pos_hi_q, pos_lo_q};
  assign pos_clamped = (pos_raw < POS_MIN) ? POS_MIN :
                       (pos_raw > POS_MAX) ? POS_MAX : pos_raw;
  assign id_ok       = (id_q < C_ID_LIMIT);
  assign ck_ok       = (rx_data_i == ck_q);
  assign to_hit      = (to_cnt_q == (TIMEOUT - 24'd1));
  // Rejected-frame counter sticks at 255 instead of wrapping.
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
  assign pkt_cnt_inc = pkt_cnt_q + 4'd1;

  // Three-flop synchroniser for the raw chip select; idles deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= 3'b111;
      tx_call_q <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[1:0], ncs_i};
      tx_call_q <= ~cs_t;
    end
  end

  // Frame FSM with timeout, checking, clamping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      id_q        <= 8'd0;
      pos_hi_q    <= 8'd0;
      pos_lo_q    <= 8'd0;
      ck_q        <= 8'd0;
      to_cnt_q    <= 24'd0;
      pkt_cnt_q   <= 4'd0;
      tx_data_q   <= 8'd0;
      servo_wr_q  <= 1'b0;
      servo_id_q  <= 5'd0;
      servo_pos_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      servo_wr_q <= 1'b0;
      if (cs_t) begin
        // Deselect drops any partial frame silently; a byte in this cycle is lost.
        state_q  <= S_HDR;
        to_cnt_q <= 24'd0;
      end else if (rx_done_i) begin
        // A received byte always beats a simultaneous timer expiry.
        to_cnt_q <= 24'd0;
        case (state_q)
          S_HDR: begin
            if (rx_data_i == HEADER) begin
              state_q <= S_ID;
            end
          end
          S_ID: begin
            id_q    <= rx_data_i;
            ck_q    <= rx_data_i;
            state_q <= S_PH;
          end
          S_PH: begin
            pos_hi_q <= rx_data_i;
            ck_q     <= ck_q ^ rx_data_i;
            state_q  <= S_PL;
          end
          S_PL: begin
            pos_lo_q <= rx_data_i;
            ck_q     <= ck_q ^ rx_data_i;
            state_q  <= S_CK;
          end
          S_CK: begin
            state_q <= S_HDR;
            if (ck_ok && id_ok) begin
              servo_wr_q  <= 1'b1;
              servo_id_q  <= id_q[4:0];
              servo_pos_q <= pos_clamped;
              pkt_cnt_q   <= pkt_cnt_inc;
              tx_data_q   <= {4'b1000, pkt_cnt_inc};
            end else if (!ck_ok) begin
              // Checksum failure takes precedence when both checks fail.
              err_cnt_q <= err_cnt_inc;
              tx_data_q <= {4'b0100, pkt_cnt_q};
            end else begin
              err_cnt_q <= err_cnt_inc;
              tx_data_q <= {4'b0010, pkt_cnt_q};
            end
          end
          default: begin
            state_q <= S_HDR;
          end
        endcase
      end else if (state_q != S_HDR) begin
        if (to_hit) begin
          state_q   <= S_HDR;
          to_cnt_q  <= 24'd0;
          err_cnt_q <= err_cnt_inc;
          tx_data_q <= {4'b0001, pkt_cnt_q};
        end else begin
          to_cnt_q <= to_cnt_q + 24'd1;
        end
      end
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_call_o   = tx_call_q;
  assign servo_wr_o  = servo_wr_q;
  assign servo_id_o  = servo_id_q;
  assign servo_pos_o = servo_pos_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_servo_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_servo_cmd_parser
// Description : Directed self-checking bench for spi_servo_cmd_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_servo_cmd_parser;

  localparam logic [23:0] C_TIMEOUT = 24'd40;

  logic        clk;
  logic        rst_n;
  logic        ncs;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_call;
  logic        servo_wr;
  logic [4:0]  servo_id;
  logic [15:0] servo_pos;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int wr_cnt   = 0;
  logic [4:0]  last_id  = 5'd0;
  logic [15:0] last_pos = 16'd0;

  spi_servo_cmd_parser #(
    .NUM_SERVO (18),
    .POS_MIN   (16'd500),
    .POS_MAX   (16'd2500),
    .TIMEOUT   (C_TIMEOUT),
    .HEADER    (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ncs_i       (ncs),
    .rx_data_i   (rx_data),
    .rx_done_i   (rx_done),
    .tx_data_o   (tx_data),
    .tx_call_o   (tx_call),
    .servo_wr_o  (servo_wr),
    .servo_id_o  (servo_id),
    .servo_pos_o (servo_pos),
    .err_cnt_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses and capture the written id/position.
  always @(negedge clk) begin
    if (servo_wr === 1'b1) begin
      wr_cnt   = wr_cnt + 1;
      last_id  = servo_id;
      last_pos = servo_pos;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
    cycles(2);
  endtask

  initial begin
    rst_n   = 1'b0;
    ncs     = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    cycles(3);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_call", 32'(tx_call), 32'h0);
    check("rst_servo_wr", 32'(servo_wr), 32'h0);
    check("rst_servo_id", 32'(servo_id), 32'h0);
    check("rst_servo_pos", 32'(servo_pos), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    cycles(2);

    ncs = 1'b0;
    cycles(5);
    check("tx_call_sel", 32'(tx_call), 32'h1);

    // Valid frame: checksum 03^05^DC = DA.
    frame(8'hA5, 8'h03, 8'h05, 8'hDC, 8'hDA);
    check("v1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("v1_id", 32'(last_id), 32'd3);
    check("v1_pos", 32'(last_pos), 32'd1500);
    check("v1_tx", 32'(tx_data), 32'h81);
    check("v1_err", 32'(err_cnt), 32'd0);
    check("v1_hold_pos", 32'(servo_pos), 32'd1500);

    frame(8'hA5, 8'h00, 8'h0B, 8'hB8, 8'hB3);
    check("clamp_hi_pos", 32'(last_pos), 32'd2500);
    check("clamp_hi_tx", 32'(tx_data), 32'h82);
    frame(8'hA5, 8'h00, 8'h00, 8'h64, 8'h64);
    check("clamp_lo_pos", 32'(last_pos), 32'd500);
    check("clamp_lo_tx", 32'(tx_data), 32'h83);
    check("clamp_wr_cnt", 32'(wr_cnt), 32'd3);

    frame(8'hA5, 8'h03, 8'h05, 8'hDC, 8'h00);
    check("badck_wr_cnt", 32'(wr_cnt), 32'd3);
    check("badck_err", 32'(err_cnt), 32'd1);
    check("badck_tx", 32'(tx_data), 32'h43);

    frame(8'hA5, 8'h14, 8'h05, 8'hDC, 8'hCD);
    check("badid_wr_cnt", 32'(wr_cnt), 32'd3);
    check("badid_err", 32'(err_cnt), 32'd2);
    check("badid_tx", 32'(tx_data), 32'h23);

    // Id boundary: 17 accepted, 18 rejected.
    frame(8'hA5, 8'h11, 8'h05, 8'hDC, 8'hC8);
    check("id17_wr_cnt", 32'(wr_cnt), 32'd4);
    check("id17_id", 32'(last_id), 32'd17);
    check("id17_tx", 32'(tx_data), 32'h84);
    frame(8'hA5, 8'h12, 8'h05, 8'hDC, 8'hCB);
    check("id18_wr_cnt", 32'(wr_cnt), 32'd4);
    check("id18_err", 32'(err_cnt), 32'd3);
    check("id18_tx", 32'(tx_data), 32'h24);

    // Resync: junk bytes before the header are ignored.
    send(8'h00); send(8'hFF);
    frame(8'hA5, 8'h01, 8'h00, 8'h64, 8'h65);
    check("resync_wr_cnt", 32'(wr_cnt), 32'd5);
    check("resync_id", 32'(last_id), 32'd1);
    check("resync_pos", 32'(last_pos), 32'd500);
    check("resync_tx", 32'(tx_data), 32'h85);

    // Timeout after a partial frame.
    send(8'hA5); send(8'h02);
    cycles(int'(C_TIMEOUT) + 20);
    check("to_err", 32'(err_cnt), 32'd4);
    check("to_tx", 32'(tx_data), 32'h15);
    frame(8'hA5, 8'h02, 8'h00, 8'h64, 8'h66);
    check("post_to_wr_cnt", 32'(wr_cnt), 32'd6);
    check("post_to_id", 32'(last_id), 32'd2);
    check("post_to_tx", 32'(tx_data), 32'h86);

    // Chip-select abort mid-frame.
    send(8'hA5); send(8'h02); send(8'h05);
    ncs = 1'b1;
    cycles(5);
    check("abort_tx_call", 32'(tx_call), 32'h0);
    check("abort_err", 32'(err_cnt), 32'd4);
    check("abort_tx", 32'(tx_data), 32'h86);
    ncs = 1'b0;
    cycles(5);
    frame(8'hA5, 8'h04, 8'h05, 8'hDC, 8'hDD);
    check("post_abort_wr_cnt", 32'(wr_cnt), 32'd7);
    check("post_abort_id", 32'(last_id), 32'd4);
    check("post_abort_pos", 32'(last_pos), 32'd1500);
    check("post_abort_tx", 32'(tx_data), 32'h87);
    check("post_abort_err", 32'(err_cnt), 32'd4);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      frame(8'hA5, 8'h03, 8'h05, 8'hDC, 8'h00);
    end
    check("sat_err", 32'(err_cnt), 32'd255);
    check("sat_wr_cnt", 32'(wr_cnt), 32'd7);
    check("sat_tx", 32'(tx_data), 32'h47);

    // Asynchronous reset between byte 4 and byte 5.
    send(8'hA5); send(8'h03); send(8'h05); send(8'hDC);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_data), 32'h00);
    check("mid_rst_tx_call", 32'(tx_call), 32'h0);
    check("mid_rst_wr", 32'(servo_wr), 32'h0);
    check("mid_rst_id", 32'(servo_id), 32'h0);
    check("mid_rst_pos", 32'(servo_pos), 32'h0);
    check("mid_rst_err", 32'(err_cnt), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("after_rst_wr_cnt", 32'(wr_cnt), 32'd7);
    frame(8'hA5, 8'h03, 8'h05, 8'hDC, 8'hDA);
    check("after_rst_wr_cnt2", 32'(wr_cnt), 32'd8);
    check("after_rst_id", 32'(last_id), 32'd3);
    check("after_rst_pos", 32'(last_pos), 32'd1500);
    check("after_rst_tx", 32'(tx_data), 32'h81);
    check("after_rst_err", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
